pipe_fetch_unit: RTL and testbench

IF stage of the pipelined MIPS core. Owns the PC register and selects the next PC from sequential, branch, jump, jr, interrupt, exception and reset sources. Drives the word address into the instruction memory and latches the returned instruction into the IF/ID pipeline register, with stall and flush support.

---
 rtl/pipe_fetch_unit.sv | 150 +++++++++++++++
 tb/tb_pipe_fetch_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_fetch_unit.sv
// pipe_fetch_unit: IF stage of the pipelined MIPS core.
// Owns the PC, picks the next PC (reset/exception/interrupt/branch/jr/j/
// stall/sequential), addresses instruction memory and fills IF/ID.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   stall                 hold PC and IF/ID
//   br_taken, br_tgt      EX-stage taken branch and its target
//   jr_req, jr_tgt        ID-stage jr and register target
//   j_req, j_index        ID-stage j/jal and instruction index
//   exc_req               ID-stage illegal instruction
//   irq                   level interrupt request
//   imem_instr            combinational instruction-memory read data
//   pc                    current fetch PC
//   imem_addr, imem_en    instruction-memory word address / output enable
//   if_id_instr, if_id_pc_plus4, if_id_valid   IF/ID pipeline register
//   flush_id              one-cycle pulse killing the instruction in ID
//   epc, epc_we           exception return address and its write strobe
module pipe_fetch_unit #(
  parameter logic [31:0] RESET_VEC = 32'h8000_0000,
  parameter logic [31:0] IRQ_VEC   = 32'h8000_0004,
  parameter logic [31:0] EXC_VEC   = 32'h8000_0008,
  parameter int unsigned IMEM_AW   = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               br_taken,
  input  logic [31:0]        br_tgt,
  input  logic               jr_req,
  input  logic [31:0]        jr_tgt,
  input  logic               j_req,
  input  logic [25:0]        j_index,
  input  logic               exc_req,
  input  logic               irq,
  input  logic [31:0]        imem_instr,
  output logic [31:0]        pc,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic               imem_en,
  output logic [31:0]        if_id_instr,
  output logic [31:0]        if_id_pc_plus4,
  output logic               if_id_valid,
  output logic               flush_id,
  output logic [31:0]        epc,
  output logic               epc_we
);

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic [31:0] pc_q, pc_d;
  logic [31:0] if_id_instr_q, if_id_instr_d;
  logic [31:0] if_id_pc_plus4_q, if_id_pc_plus4_d;
  logic        if_id_valid_q, if_id_valid_d;
  logic        flush_id_q, flush_id_d;
  logic [31:0] epc_q, epc_d;
  logic        epc_we_q, epc_we_d;

  logic [31:0] pc_seq;
  logic [31:0] j_tgt;
  logic        irq_take;

  // Increment keeps the supervisor bit; carry out of bit 30 is dropped.
  assign pc_seq   = {pc_q[31], pc_q[30:0] + 31'd4};
  assign j_tgt    = {if_id_pc_plus4_q[31:28], j_index, 2'b00};
  // Interrupts are masked in supervisor space and while stalled.
  assign irq_take = irq && !pc_q[31] && !stall;

  // Next-PC / IF-ID selection; redirects leave a bubble whose pc_plus4
  // records target+4 for debug.
  always_comb begin
    pc_d             = pc_q;
    if_id_instr_d    = if_id_instr_q;
    if_id_pc_plus4_d = if_id_pc_plus4_q;
    if_id_valid_d    = if_id_valid_q;
    epc_d            = epc_q;
    flush_id_d       = 1'b0;
    epc_we_d         = 1'b0;

    if (exc_req) begin
      pc_d             = EXC_VEC;
      epc_d            = if_id_pc_plus4_q;
      epc_we_d         = 1'b1;
      flush_id_d       = 1'b1;
      if_id_instr_d    = NOP;
      if_id_valid_d    = 1'b0;
      if_id_pc_plus4_d = EXC_VEC + 32'd4;
    end else if (irq_take) begin
      pc_d             = IRQ_VEC;
      epc_d            = pc_q;  // unfetched instruction is retried on return
      epc_we_d         = 1'b1;
      if_id_instr_d    = NOP;
      if_id_valid_d    = 1'b0;
      if_id_pc_plus4_d = IRQ_VEC + 32'd4;
    end else if (br_taken) begin
      pc_d             = br_tgt;
      flush_id_d       = 1'b1;
      if_id_instr_d    = NOP;
      if_id_valid_d    = 1'b0;
      if_id_pc_plus4_d = br_tgt + 32'd4;
    end else if (jr_req) begin
      pc_d             = jr_tgt;
      if_id_instr_d    = NOP;
      if_id_valid_d    = 1'b0;
      if_id_pc_plus4_d = jr_tgt + 32'd4;
    end else if (j_req) begin
      pc_d             = j_tgt;
      if_id_instr_d    = NOP;
      if_id_valid_d    = 1'b0;
      if_id_pc_plus4_d = j_tgt + 32'd4;
    end else if (stall) begin
      pc_d             = pc_q;
    end else begin
      pc_d             = pc_seq;
      if_id_instr_d    = imem_instr;
      if_id_pc_plus4_d = pc_seq;
      if_id_valid_d    = 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q             <= RESET_VEC;
      if_id_instr_q    <= 32'h0;
      if_id_pc_plus4_q <= 32'h0;
      if_id_valid_q    <= 1'b0;
      flush_id_q       <= 1'b0;
      epc_q            <= 32'h0;
      epc_we_q         <= 1'b0;
    end else begin
      pc_q             <= pc_d;
      if_id_instr_q    <= if_id_instr_d;
      if_id_pc_plus4_q <= if_id_pc_plus4_d;
      if_id_valid_q    <= if_id_valid_d;
      flush_id_q       <= flush_id_d;
      epc_q            <= epc_d;
      epc_we_q         <= epc_we_d;
    end
  end

  assign pc             = pc_q;
  assign imem_addr      = pc_q[IMEM_AW+1:2];  // wraps modulo 2^IMEM_AW
  assign imem_en        = ~reset;
  assign if_id_instr    = if_id_instr_q;
  assign if_id_pc_plus4 = if_id_pc_plus4_q;
  assign if_id_valid    = if_id_valid_q;
  assign flush_id       = flush_id_q;
  assign epc            = epc_q;
  assign epc_we         = epc_we_q;

endmodule

// File: tb/tb_pipe_fetch_unit.sv
// Directed bench for pipe_fetch_unit; memory returns address-tagged words.
module tb_pipe_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, br_taken, jr_req, j_req, exc_req, irq;
  logic [31:0] br_tgt, jr_tgt;
  logic [25:0] j_index;
  logic [31:0] imem_instr;
  logic [31:0] pc;
  logic [6:0]  imem_addr;
  logic        imem_en;
  logic [31:0] if_id_instr, if_id_pc_plus4;
  logic        if_id_valid, flush_id, epc_we;
  logic [31:0] epc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign imem_instr = 32'hCAFE_0000 | 32'(imem_addr);

  pipe_fetch_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .br_taken(br_taken),
    .br_tgt(br_tgt), .jr_req(jr_req), .jr_tgt(jr_tgt), .j_req(j_req),
    .j_index(j_index), .exc_req(exc_req), .irq(irq), .imem_instr(imem_instr),
    .pc(pc), .imem_addr(imem_addr), .imem_en(imem_en),
    .if_id_instr(if_id_instr), .if_id_pc_plus4(if_id_pc_plus4),
    .if_id_valid(if_id_valid), .flush_id(flush_id), .epc(epc), .epc_we(epc_we)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_jr(input logic [31:0] tgt);
    jr_req = 1'b1;
    jr_tgt = tgt;
    step();
    jr_req = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pc"}, pc, 32'h8000_0000);
    chk({tag, "_instr"}, if_id_instr, 32'h0);
    chk({tag, "_pc4"}, if_id_pc_plus4, 32'h0);
    chk({tag, "_valid"}, 32'(if_id_valid), 32'h0);
    chk({tag, "_flush"}, 32'(flush_id), 32'h0);
    chk({tag, "_epc"}, epc, 32'h0);
    chk({tag, "_epcwe"}, 32'(epc_we), 32'h0);
    chk({tag, "_imem_en"}, 32'(imem_en), 32'h0);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; br_taken = 1'b0; jr_req = 1'b0; j_req = 1'b0;
    exc_req = 1'b0; irq = 1'b0; br_tgt = '0; jr_tgt = '0; j_index = '0;
    #3;
    chk_reset_vals("rst");
    step();
    reset = 1'b0;
    #1;
    chk("imem_en", 32'(imem_en), 32'h1);

    // Free-running fetch from the reset vector.
    step();
    chk("seq1_pc", pc, 32'h8000_0004);
    chk("seq1_pc4", if_id_pc_plus4, 32'h8000_0004);
    chk("seq1_instr", if_id_instr, 32'hCAFE_0000);
    chk("seq1_valid", 32'(if_id_valid), 32'h1);
    step();
    chk("seq2_pc", pc, 32'h8000_0008);
    chk("seq2_instr", if_id_instr, 32'hCAFE_0001);
    step();
    chk("seq3_pc", pc, 32'h8000_000C);
    chk("seq3_pc4", if_id_pc_plus4, 32'h8000_000C);

    // jr redirect, then imem_addr wrap and bit 31 preserved.
    do_jr(32'h8000_01FC);
    chk("jr1_pc", pc, 32'h8000_01FC);
    chk("jr1_valid", 32'(if_id_valid), 32'h0);
    chk("jr1_instr", if_id_instr, 32'h0);
    chk("jr1_pc4", if_id_pc_plus4, 32'h8000_0200);
    step();
    chk("wrap_pc", pc, 32'h8000_0200);
    chk("wrap_addr", 32'(imem_addr), 32'h0);
    chk("wrap_instr", if_id_instr, 32'hCAFE_007F);

    // Stall holds, taken branch overrides stall.
    do_jr(32'h0000_003C);
    step();
    chk("pre_stall_pc", pc, 32'h0000_0040);
    chk("pre_stall_instr", if_id_instr, 32'hCAFE_000F);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", pc, 32'h0000_0040);
      chk("stall_instr", if_id_instr, 32'hCAFE_000F);
      chk("stall_pc4", if_id_pc_plus4, 32'h0000_0040);
      chk("stall_valid", 32'(if_id_valid), 32'h1);
    end
    br_taken = 1'b1; br_tgt = 32'h0000_0100;
    step();
    chk("br_pc", pc, 32'h0000_0100);
    chk("br_flush", 32'(flush_id), 32'h1);
    chk("br_valid", 32'(if_id_valid), 32'h0);
    chk("br_pc4", if_id_pc_plus4, 32'h0000_0104);
    br_taken = 1'b0; stall = 1'b0;
    step();
    chk("br_flush_clr", 32'(flush_id), 32'h0);
    chk("br_next_pc", pc, 32'h0000_0104);
    chk("br_next_instr", if_id_instr, 32'hCAFE_0040);

    // Jump uses upper bits of if_id_pc_plus4.
    do_jr(32'h0000_007C);
    step();
    chk("pre_j_pc4", if_id_pc_plus4, 32'h0000_0080);
    j_req = 1'b1; j_index = 26'h40;
    step();
    j_req = 1'b0;
    chk("j_pc", pc, 32'h0000_0100);
    chk("j_valid", 32'(if_id_valid), 32'h0);
    chk("j_instr", if_id_instr, 32'h0);
    do_jr(32'h8000_0014);
    chk("jr2_pc", pc, 32'h8000_0014);

    // Interrupt entry and masking in supervisor space.
    do_jr(32'h0000_0030);
    irq = 1'b1;
    step();
    chk("irq_pc", pc, 32'h8000_0004);
    chk("irq_epc", epc, 32'h0000_0030);
    chk("irq_epcwe", 32'(epc_we), 32'h1);
    chk("irq_valid", 32'(if_id_valid), 32'h0);
    chk("irq_flush", 32'(flush_id), 32'h0);
    step();
    chk("irq_mask_pc", pc, 32'h8000_0008);
    chk("irq_mask_epcwe", 32'(epc_we), 32'h0);
    chk("irq_mask_epc", epc, 32'h0000_0030);
    irq = 1'b0;

    // Exception beats a simultaneous interrupt.
    do_jr(32'h0000_004C);
    step();
    chk("pre_exc_pc4", if_id_pc_plus4, 32'h0000_0050);
    irq = 1'b1; exc_req = 1'b1;
    step();
    chk("exc_pc", pc, 32'h8000_0008);
    chk("exc_epc", epc, 32'h0000_0050);
    chk("exc_epcwe", 32'(epc_we), 32'h1);
    chk("exc_flush", 32'(flush_id), 32'h1);
    chk("exc_valid", 32'(if_id_valid), 32'h0);
    irq = 1'b0; exc_req = 1'b0;
    step();
    chk("exc_flush_clr", 32'(flush_id), 32'h0);
    chk("exc_epcwe_clr", 32'(epc_we), 32'h0);

    // Asynchronous reset in the middle of a stall.
    stall = 1'b1;
    step();
    reset = 1'b1;
    #1;
    chk_reset_vals("arst");
    step();
    stall = 1'b0;
    reset = 1'b0;
    step();
    chk("post_rst_pc", pc, 32'h8000_0004);
    chk("post_rst_instr", if_id_instr, 32'hCAFE_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
